// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: load-use stall FSM, mult/div busy tracking,
// branch flush priority and a saturating stall-cycle counter.
module hazard_ctrl #(
   parameter int REG_AW      = 5,
   parameter int LOAD_STALL  = 1,
   parameter int MD_LAT      = 4,
   parameter int ZERO_EXEMPT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_ex_mem_read,
   input  logic [REG_AW-1:0] id_ex_rt,
   input  logic [REG_AW-1:0] if_id_rs,
   input  logic [REG_AW-1:0] if_id_rt,
   input  logic              if_id_uses_rt,
   input  logic              if_id_reads_hilo,
   input  logic              md_start,
   input  logic              branch_taken,
   output logic              pc_write,
   output logic              if_id_write,
   output logic              bubble_sel,
   output logic              if_id_flush,
   output logic              md_busy,
   output logic [15:0]       stall_cycles
);

   typedef enum logic {IDLE, LSTALL} state_t;

   localparam logic [2:0] LS_INIT = 3'(LOAD_STALL - 1);
   localparam logic [5:0] MD_INIT = 6'(MD_LAT);
   localparam logic       ZX      = (ZERO_EXEMPT != 0);

   state_t      state;
   logic [2:0]  lcnt;
   logic [5:0]  mcnt;
   logic        raw_hit;
   logic        load_hit;
   logic        hilo_hit;
   logic        stall;

   assign raw_hit  = id_ex_mem_read &
                     ((id_ex_rt == if_id_rs) |
                      (if_id_uses_rt & (id_ex_rt == if_id_rt)));
   assign load_hit = raw_hit & ~(ZX & (id_ex_rt == '0));
   assign md_busy  = (mcnt != 6'd0);
   assign hilo_hit = if_id_reads_hilo & md_busy;
   assign stall    = ((state == IDLE) & load_hit) |
                     (state == LSTALL) | hilo_hit;

   assign pc_write    = ~stall | branch_taken;
   assign if_id_write = ~stall;
   assign bubble_sel  = stall;
   assign if_id_flush = branch_taken;

   // The hit cycle itself is the first stall cycle, so LSTALL covers
   // the remaining LOAD_STALL-1 cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         lcnt  <= 3'd0;
      end else if (branch_taken) begin
         state <= IDLE;
         lcnt  <= 3'd0;
      end else begin
         unique case (state)
            IDLE: begin
               if (load_hit && LOAD_STALL > 1) begin
                  state <= LSTALL;
                  lcnt  <= LS_INIT;
               end
            end
            LSTALL: begin
               if (lcnt <= 3'd1) begin
                  state <= IDLE;
                  lcnt  <= 3'd0;
               end else begin
                  lcnt <= lcnt - 3'd1;
               end
            end
            default: begin
               state <= IDLE;
               lcnt  <= 3'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcnt <= 6'd0;
      end else if (md_start) begin
         mcnt <= MD_INIT;
      end else if (mcnt != 6'd0) begin
         mcnt <= mcnt - 6'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles <= 16'd0;
      end else if (stall && !branch_taken &&
                   stall_cycles != 16'hFFFF) begin
         stall_cycles <= stall_cycles + 16'd1;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: random and directed stimulus checked
// against a countdown reference model.
module tb_hazard_ctrl;

   localparam int AW = 5;
   localparam int LS = 3;
   localparam int ML = 4;

   typedef struct packed {
      logic        pc;
      logic        ifw;
      logic        bub;
      logic        fl;
      logic        busy;
      logic [15:0] sc;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          mr = 1'b0;
   logic [AW-1:0] ex_rt = '0;
   logic [AW-1:0] rs = '0;
   logic [AW-1:0] rt = '0;
   logic          ur = 1'b0;
   logic          hilo = 1'b0;
   logic          ms = 1'b0;
   logic          br = 1'b0;
   logic          pc_write;
   logic          if_id_write;
   logic          bubble_sel;
   logic          if_id_flush;
   logic          md_busy;
   logic [15:0]   stall_cycles;

   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t q[$];
   int   lrem = 0;
   int   mrem = 0;
   int   cnt  = 0;

   hazard_ctrl #(
      .REG_AW(AW), .LOAD_STALL(LS), .MD_LAT(ML), .ZERO_EXEMPT(1)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .id_ex_mem_read(mr), .id_ex_rt(ex_rt),
      .if_id_rs(rs), .if_id_rt(rt), .if_id_uses_rt(ur),
      .if_id_reads_hilo(hilo), .md_start(ms),
      .branch_taken(br),
      .pc_write(pc_write), .if_id_write(if_id_write),
      .bubble_sel(bubble_sel), .if_id_flush(if_id_flush),
      .md_busy(md_busy), .stall_cycles(stall_cycles)
   );

   always #5 clk = ~clk;

   function automatic exp_t actual();
      exp_t a;
      a = {pc_write, if_id_write, bubble_sel, if_id_flush,
           md_busy, stall_cycles};
      return a;
   endfunction

   task automatic chk(input string nm, input exp_t a, input exp_t e);
      n_cmp++;
      if (a !== e) begin
         n_bad++;
         $display("FAIL %s t=%0t got pc=%b ifw=%b bub=%b fl=%b busy=%b sc=%0d want pc=%b ifw=%b bub=%b fl=%b busy=%b sc=%0d",
                  nm, $time, a.pc, a.ifw, a.bub, a.fl, a.busy, a.sc,
                  e.pc, e.ifw, e.bub, e.fl, e.busy, e.sc);
      end
   endtask

   // Monitor: outputs settle by negedge+3, well before the next posedge.
   always @(negedge clk) begin
      #3;
      if (q.size() > 0) chk("cycle", actual(), q.pop_front());
   end

   // One clock of stimulus; the model predicts this cycle's outputs and
   // then advances its remaining-cycle counters.
   task automatic step(input logic m, input logic [AW-1:0] er,
                       input logic [AW-1:0] s, input logic [AW-1:0] t,
                       input logic u, input logic h, input logic st,
                       input logic b);
      exp_t e;
      bit   hit, busy, stl;
      @(negedge clk);
      mr = m; ex_rt = er; rs = s; rt = t; ur = u;
      hilo = h; ms = st; br = b;
      hit  = m && er != 0 && (er == s || (u && er == t));
      busy = mrem > 0;
      stl  = lrem > 0 || hit || (h && busy);
      e.pc   = !stl || b;
      e.ifw  = !stl;
      e.bub  = stl;
      e.fl   = b;
      e.busy = busy;
      e.sc   = 16'(cnt);
      q.push_back(e);
      if (b) lrem = 0;
      else if (lrem > 0) lrem--;
      else if (hit) lrem = LS - 1;
      mrem = st ? ML : (mrem > 0 ? mrem - 1 : 0);
      if (stl && !b && cnt < 65535) cnt++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic drain();
      int k;
      k = 0;
      while (q.size() > 0 && k < 10) begin
         @(posedge clk);
         k++;
      end
      if (q.size() > 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain timeout pending=%0d", q.size());
         q.delete();
      end
   endtask

   task automatic do_reset(input string nm);
      exp_t r;
      r = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
      drain();
      @(posedge clk);
      #2;
      rst_n = 0;
      mr = 0; ex_rt = 0; rs = 0; rt = 0; ur = 0;
      hilo = 0; ms = 0; br = 0;
      #1;
      chk(nm, actual(), r);
      @(posedge clk);
      #1;
      chk({nm, "_hold"}, actual(), r);
      @(negedge clk);
      rst_n = 1;
      lrem = 0; mrem = 0; cnt = 0;
   endtask

   initial begin
      #1;
      chk("reset0", actual(), {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0});
      @(negedge clk);
      @(negedge clk);
      rst_n = 1;
      idle(2);
      // load r5 hitting rs, then cleared: three stall cycles
      step(1, 5, 5, 0, 0, 0, 0, 0);
      idle(4);
      // r0 exempt, and rt match without uses_rt
      step(1, 0, 0, 0, 1, 0, 0, 0);
      step(1, 7, 1, 7, 0, 0, 0, 0);
      idle(1);
      // rt match with uses_rt
      step(1, 7, 1, 7, 1, 0, 0, 0);
      idle(3);
      // mult then mfhi held until busy drops
      step(0, 0, 0, 0, 0, 0, 1, 0);
      for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 1, 0, 0);
      // branch in second LSTALL cycle
      step(1, 3, 3, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 1);
      idle(2);
      // md_start re-issued while busy supersedes
      step(0, 0, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0, 1, 1, 0);
      for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 1, 0, 0);
      // random traffic on a small register space
      for (int i = 0; i < 600; i++)
         step($urandom_range(0, 1), AW'($urandom_range(0, 3)),
              AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)),
              $urandom_range(0, 1), $urandom_range(0, 1),
              ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 9) == 0));
      // abort mid-LSTALL and mid-busy
      step(0, 0, 0, 0, 0, 0, 1, 0);
      step(1, 2, 2, 0, 0, 0, 0, 0);
      do_reset("rst_mid");
      step(0, 0, 0, 0, 0, 1, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0);
      idle(2);
      // long continuous stall drives counter to saturation
      for (int i = 0; i < 70000; i++)
         step(0, 0, 0, 0, 0, 1, 1, 0);
      idle(2);
      drain();
      n_cmp++;
      if (stall_cycles !== 16'hFFFF) begin
         n_bad++;
         $display("FAIL sat got=%h want=ffff", stall_cycles);
      end
      do_reset("rst_sat");
      idle(3);
      drain();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
